// File: rtl/fpu_arb_pkg.sv
// Shared types and constants for the two-requester FP64 adder arbiter.
package fpu_arb_pkg;
    typedef enum logic [1:0] {IDLE, INFLIGHT, HOLD} slot_state_e;
    localparam int NUM_REQ     = 2;
    localparam int ADD_LAT_DEF = 1;
endpackage

// File: rtl/fpu_arb_slot.sv
// Per-requester slot: tracks one outstanding add and holds its result until the requester takes it.
// Result visible the cycle after capture; held stable while rsp_ready_i is low.
module fpu_arb_slot
    import fpu_arb_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        accept_i,
    input  logic        capture_i,
    input  logic [63:0] cap_dat_i,
    input  logic        rsp_ready_i,
    output logic        idle_o,
    output logic        rsp_valid_o,
    output logic [63:0] rsp_data_o
);
    slot_state_e state_q;
    logic [63:0] data_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_i) state_q <= INFLIGHT;
                end
                INFLIGHT: begin
                    if (capture_i) begin
                        state_q <= HOLD;
                        data_q  <= cap_dat_i;
                    end
                end
                HOLD: begin
                    if (rsp_ready_i) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign idle_o      = (state_q == IDLE);
    assign rsp_valid_o = (state_q == HOLD);
    assign rsp_data_o  = data_q;
endmodule

// File: rtl/fpu_add_arb.sv
// Round-robin arbiter sharing one pipelined FP64 adder between two requesters.
// Result returns ADD_LAT cycles after accept; a requester stalls while its slot is busy or unread.
module fpu_add_arb
    import fpu_arb_pkg::*;
#(
    parameter int ADD_LAT = ADD_LAT_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [63:0] req0_srca,
    input  logic [63:0] req0_srcb,
    input  logic        req0_sub,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [63:0] req1_srca,
    input  logic [63:0] req1_srcb,
    input  logic        req1_sub,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [63:0] rsp0_data,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [63:0] rsp1_data,
    output logic        add_enable,
    output logic        add_doSub,
    output logic [63:0] add_srca,
    output logic [63:0] add_srcb,
    input  logic [63:0] add_dst,
    output logic        busy
);
    logic [NUM_REQ-1:0] req_vld, rsp_rdy, slot_idle, elig, gnt, cap, rsp_vld;
    logic [63:0]        rsp_dat [NUM_REQ];
    logic               accept;
    logic               rr_q;
    logic [63:0]        srca_q, srcb_q, srca_d, srcb_d;
    logic               sub_q, sub_d;
    logic [ADD_LAT-1:0] pipe_vld_q, pipe_tag_q;

    assign req_vld = {req1_valid, req0_valid};
    assign rsp_rdy = {rsp1_ready, rsp0_ready};
    assign elig    = req_vld & slot_idle;

    // rr_q holds the most recent grantee; on a tie the other requester wins.
    assign gnt[0] = elig[0] & (~elig[1] | rr_q);
    assign gnt[1] = elig[1] & (~elig[0] | ~rr_q);
    assign accept = |gnt;

    assign srca_d = gnt[1] ? req1_srca : req0_srca;
    assign srcb_d = gnt[1] ? req1_srcb : req0_srcb;
    assign sub_d  = gnt[1] ? req1_sub  : req0_sub;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_q       <= 1'b1;
            srca_q     <= '0;
            srcb_q     <= '0;
            sub_q      <= 1'b0;
            pipe_vld_q <= '0;
            pipe_tag_q <= '0;
        end else begin
            pipe_vld_q[0] <= accept;
            pipe_tag_q[0] <= gnt[1];
            for (int k = 1; k < ADD_LAT; k++) begin
                pipe_vld_q[k] <= pipe_vld_q[k-1];
                pipe_tag_q[k] <= pipe_tag_q[k-1];
            end
            if (accept) begin
                rr_q   <= gnt[1];
                srca_q <= srca_d;
                srcb_q <= srcb_d;
                sub_q  <= sub_d;
            end
        end
    end

    for (genvar n = 0; n < NUM_REQ; n++) begin : g_slot
        assign cap[n] = pipe_vld_q[ADD_LAT-1] & (pipe_tag_q[ADD_LAT-1] == 1'(n));

        fpu_arb_slot u_slot (
            .clk         (clk),
            .reset_n     (reset_n),
            .accept_i    (gnt[n]),
            .capture_i   (cap[n]),
            .cap_dat_i   (add_dst),
            .rsp_ready_i (rsp_rdy[n]),
            .idle_o      (slot_idle[n]),
            .rsp_valid_o (rsp_vld[n]),
            .rsp_data_o  (rsp_dat[n])
        );
    end

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign rsp0_valid = rsp_vld[0];
    assign rsp1_valid = rsp_vld[1];
    assign rsp0_data  = rsp_dat[0];
    assign rsp1_data  = rsp_dat[1];
    assign add_enable = pipe_vld_q[0];
    assign add_doSub  = sub_q;
    assign add_srca   = srca_q;
    assign add_srcb   = srcb_q;
    assign busy       = ~&slot_idle;
endmodule

// File: tb/tb_fpu_add_arb.sv
// Directed bench for fpu_add_arb: instance 0 runs ADD_LAT=1, instance 1 runs ADD_LAT=3.
module tb_fpu_add_arb;
    localparam logic [63:0] F1   = 64'h3FF0_0000_0000_0000;
    localparam logic [63:0] F2   = 64'h4000_0000_0000_0000;
    localparam logic [63:0] F3   = 64'h4008_0000_0000_0000;
    localparam logic [63:0] F4   = 64'h4010_0000_0000_0000;
    localparam logic [63:0] JUNK = 64'hDEAD_BEEF_DEAD_BEEF;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [1:0]  req0_valid, req1_valid, req0_sub, req1_sub, rsp0_ready, rsp1_ready;
    logic [1:0]  req0_ready, req1_ready, rsp0_valid, rsp1_valid, add_enable, add_doSub, busy;
    logic [63:0] req0_srca [2];
    logic [63:0] req0_srcb [2];
    logic [63:0] req1_srca [2];
    logic [63:0] req1_srcb [2];
    logic [63:0] rsp0_data [2];
    logic [63:0] rsp1_data [2];
    logic [63:0] add_srca  [2];
    logic [63:0] add_srcb  [2];
    logic [63:0] add_dst   [2];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [63:0] fp_add(input logic [63:0] a, input logic [63:0] b, input logic sub);
        real x, y;
        x = $bitstoreal(a);
        y = $bitstoreal(b);
        return $realtobits(sub ? x - y : x + y);
    endfunction

    // Stand-in adder: garbage unless enabled, so mistimed captures are visible.
    for (genvar d = 0; d < 2; d++) begin : g_dut
        logic [63:0] sum, p0, p1;
        assign sum = add_enable[d] ? fp_add(add_srca[d], add_srcb[d], add_doSub[d]) : JUNK;
        always @(posedge clk) begin
            p0 <= sum;
            p1 <= p0;
        end
        if (d == 0) begin : g_lat1
            assign add_dst[d] = sum;
        end else begin : g_lat3
            assign add_dst[d] = p1;
        end

        fpu_add_arb #(.ADD_LAT(d == 0 ? 1 : 3)) u_dut (
            .clk        (clk),
            .reset_n    (reset_n),
            .req0_valid (req0_valid[d]),
            .req0_ready (req0_ready[d]),
            .req0_srca  (req0_srca[d]),
            .req0_srcb  (req0_srcb[d]),
            .req0_sub   (req0_sub[d]),
            .req1_valid (req1_valid[d]),
            .req1_ready (req1_ready[d]),
            .req1_srca  (req1_srca[d]),
            .req1_srcb  (req1_srcb[d]),
            .req1_sub   (req1_sub[d]),
            .rsp0_valid (rsp0_valid[d]),
            .rsp0_ready (rsp0_ready[d]),
            .rsp0_data  (rsp0_data[d]),
            .rsp1_valid (rsp1_valid[d]),
            .rsp1_ready (rsp1_ready[d]),
            .rsp1_data  (rsp1_data[d]),
            .add_enable (add_enable[d]),
            .add_doSub  (add_doSub[d]),
            .add_srca   (add_srca[d]),
            .add_srcb   (add_srcb[d]),
            .add_dst    (add_dst[d]),
            .busy       (busy[d])
        );
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        req0_valid = '0; req1_valid = '0; req0_sub = '0; req1_sub = '0;
        rsp0_ready = '0; rsp1_ready = '0;
        for (int d = 0; d < 2; d++) begin
            req0_srca[d] = '0; req0_srcb[d] = '0;
            req1_srca[d] = '0; req1_srcb[d] = '0;
        end

        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy",  busy[0], 0);
        chk("rst_en",    add_enable[0], 0);
        chk("rst_srca",  add_srca[0], 0);
        chk("rst_rsp0v", rsp0_valid[0], 0);
        chk("rst_rsp1d", rsp1_data[0], 0);

        // Tie at the first edge after reset
        @(negedge clk);
        reset_n = 1'b1;
        req0_valid[0] = 1; req0_srca[0] = F1; req0_srcb[0] = F2; req0_sub[0] = 0;
        req1_valid[0] = 1; req1_srca[0] = F3; req1_srcb[0] = F1; req1_sub[0] = 1;
        rsp0_ready[0] = 1; rsp1_ready[0] = 1;
        #1;
        chk("tie_r0rdy", req0_ready[0], 1);
        chk("tie_r1rdy", req1_ready[0], 0);
        @(negedge clk);
        req0_valid[0] = 0;
        #1;
        chk("tie_r1rdy2", req1_ready[0], 1);
        chk("iss0_en",    add_enable[0], 1);
        chk("iss0_a",     add_srca[0], F1);
        chk("iss0_b",     add_srcb[0], F2);
        @(negedge clk);
        req1_valid[0] = 0;
        #1;
        chk("tie_rsp0v",  rsp0_valid[0], 1);
        chk("tie_rsp0d",  rsp0_data[0], F3);
        chk("tie_rsp1v",  rsp1_valid[0], 0);
        chk("iss1_sub",   add_doSub[0], 1);
        @(negedge clk);
        #1;
        chk("tie_rsp1v2", rsp1_valid[0], 1);
        chk("tie_rsp1d",  rsp1_data[0], F2);
        chk("tie_rsp0v2", rsp0_valid[0], 0);
        @(negedge clk);
        #1;
        chk("tie_busy",   busy[0], 0);

        // Single add, latency 1
        rsp0_ready[0] = 0;
        req0_valid[0] = 1; req0_srca[0] = F1; req0_srcb[0] = F2; req0_sub[0] = 0;
        #1;
        chk("a_rdy", req0_ready[0], 1);
        @(negedge clk);
        req0_valid[0] = 0;
        #1;
        chk("a_rsp0v_early", rsp0_valid[0], 0);
        chk("a_busy",        busy[0], 1);
        @(negedge clk);
        #1;
        chk("a_rsp0v",   rsp0_valid[0], 1);
        chk("a_rsp0d",   rsp0_data[0], F3);
        chk("a_en_off",  add_enable[0], 0);
        chk("a_hold_a",  add_srca[0], F1);
        rsp0_ready[0] = 1;
        @(negedge clk);
        #1;
        chk("a_drain", rsp0_valid[0], 0);
        rsp0_ready[0] = 0;

        // Subtract on requester 1 with the response stalled
        req1_valid[0] = 1; req1_srca[0] = F3; req1_srcb[0] = F1; req1_sub[0] = 1;
        rsp1_ready[0] = 0;
        @(negedge clk);
        #1;
        chk("c_rdy_infl", req1_ready[0], 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("c_hold_v",   rsp1_valid[0], 1);
            chk("c_hold_d",   rsp1_data[0], F2);
            chk("c_hold_rdy", req1_ready[0], 0);
        end
        rsp1_ready[0] = 1;
        #1;
        chk("c_same_edge_rdy", req1_ready[0], 0);
        @(negedge clk);
        #1;
        chk("c_drained",  rsp1_valid[0], 0);
        chk("c_reacc_rdy", req1_ready[0], 1);
        @(negedge clk);
        req1_valid[0] = 0;
        #1;
        chk("c_reacc_busy", busy[0], 1);
        chk("c_reacc_en",   add_enable[0], 1);
        @(negedge clk);
        #1;
        chk("c_reacc_v", rsp1_valid[0], 1);
        chk("c_reacc_d", rsp1_data[0], F2);
        @(negedge clk);
        rsp1_ready[0] = 0;

        // Reset while requester 0 is in flight
        req0_valid[0] = 1; req0_srca[0] = F1; req0_srcb[0] = F2; req0_sub[0] = 0;
        @(negedge clk);
        req0_valid[0] = 0;
        reset_n = 1'b0;
        #1;
        chk("d_busy", busy[0], 0);
        chk("d_rsp0v", rsp0_valid[0], 0);
        chk("d_en", add_enable[0], 0);
        chk("d_srca", add_srca[0], 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            chk("d_rsp0v_after", rsp0_valid[0], 0);
            chk("d_busy_after",  busy[0], 0);
        end
        req0_valid[0] = 1; req0_srca[0] = F3; req0_srcb[0] = F1; req0_sub[0] = 0;
        rsp0_ready[0] = 1;
        @(negedge clk);
        req0_valid[0] = 0;
        @(negedge clk);
        #1;
        chk("d_new_v", rsp0_valid[0], 1);
        chk("d_new_d", rsp0_data[0], F4);
        @(negedge clk);
        rsp0_ready[0] = 0;

        // Back-to-back issue on the latency-3 instance
        req0_valid[1] = 1; req0_srca[1] = F1; req0_srcb[1] = F2; req0_sub[1] = 0;
        req1_valid[1] = 1; req1_srca[1] = F3; req1_srcb[1] = F1; req1_sub[1] = 1;
        rsp0_ready[1] = 1; rsp1_ready[1] = 1;
        #1;
        chk("e_r0rdy", req0_ready[1], 1);
        @(negedge clk);
        req0_valid[1] = 0;
        #1;
        chk("e_en0", add_enable[1], 1);
        chk("e_a0",  add_srca[1], F1);
        @(negedge clk);
        req1_valid[1] = 0;
        #1;
        chk("e_en1",   add_enable[1], 1);
        chk("e_a1",    add_srca[1], F3);
        chk("e_sub1",  add_doSub[1], 1);
        chk("e_r0v_1", rsp0_valid[1], 0);
        @(negedge clk);
        #1;
        chk("e_en_off", add_enable[1], 0);
        chk("e_r0v_2",  rsp0_valid[1], 0);
        @(negedge clk);
        #1;
        chk("e_r0v", rsp0_valid[1], 1);
        chk("e_r0d", rsp0_data[1], F3);
        chk("e_r1v_early", rsp1_valid[1], 0);
        @(negedge clk);
        #1;
        chk("e_r1v", rsp1_valid[1], 1);
        chk("e_r1d", rsp1_data[1], F2);
        chk("e_r0v_done", rsp0_valid[1], 0);
        @(negedge clk);
        #1;
        chk("e_busy", busy[1], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
